adder_share_arbiter: RTL and testbench
======================================

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters, fixed at 4 in this revision.
REQ-002 The block SHALL have parameter W, default 64: operand and sum width, fixed at 64 to match kogg_stone_64.
REQ-003 The block SHALL have port clk  input  1  the only clock; all state is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester operand-valid.
REQ-006 The block SHALL have port req_ready  output  NREQ  per-requester accept, at most one bit high per cycle.
REQ-007 The block SHALL have port req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-008 The block SHALL have port req_b  input  NREQ*W  operand B, packed the same way as req_a.
REQ-009 The block SHALL have port rsp_valid  output  1  result valid.
REQ-010 The block SHALL have port rsp_ready  input  1  downstream accepts the result.
REQ-011 The block SHALL have port rsp_sum  output  W  the sum (a+b) mod 2^64, with carry-out discarded.
REQ-012 The block SHALL have port rsp_id  output  2  index of the requester that owns rsp_sum.

Function
REQ-013 Transfers SHALL occur on the rising edge of clk: on req_valid[i]&req_ready[i] at the requester side, and on rsp_valid&rsp_ready at the response side.
REQ-014 Pipeline SHALL be: stage 1 = registered operands+id (s1_valid); adder combinational on stage-1 registers; stage 2 = registered sum+id (rsp_valid).
REQ-015 Latency SHALL be: operands accepted at edge N SHALL present rsp_valid=1 after edge N+1 (visible in cycle N+1 to N+2) when not stalled; 2 edges from accept to result register.
REQ-016 Stage enables SHALL be: s2_en = !rsp_valid | rsp_ready; s1_en = !s1_valid | s2_en.
REQ-017 req_ready[i] SHALL be s1_en & grant[i], where grant is one-hot round-robin over req_valid starting at pointer ptr.
REQ-018 req_ready SHALL be combinational from req_valid, ptr and pipeline state; it SHALL NOT depend on req_a/req_b.
REQ-019 ptr SHALL update only on an accepted transfer: ptr <= (granted index + 1) mod 4, so 3 wraps to 0; with no accept, ptr SHALL hold.
REQ-020 Throughput SHALL be one accept per cycle when rsp_ready is held high; sustained back-to-back with no bubbles.
REQ-021 While rsp_valid=1 and rsp_ready=0, rsp_sum and rsp_id SHALL remain stable; stage 1 SHALL hold if occupied; req_ready SHALL then be all 0.
REQ-022 When the response is accepted and a new accept occurs in the same cycle, both stages SHALL advance simultaneously with no loss or duplication.
REQ-023 Responses SHALL be in accept order; no reordering.
REQ-024 When no requester is valid, the block SHALL grant nothing and ptr SHALL be unchanged.

Reset
REQ-025 When reset=1 at an edge, s1_valid, rsp_valid and ptr SHALL become 0, and rsp_sum and rsp_id SHALL become 0.
REQ-026 req_ready SHALL be all 0 in any cycle in which reset=1.
REQ-027 In-flight operations SHALL be discarded on reset mid-operation; no response SHALL be produced for them.

Structure
REQ-028 Package adder_share_pkg SHALL hold NREQ, W, ID_W=2, and typedef req_id_t.
REQ-029 Round-robin grant logic SHALL be sub-module rr_arbiter_4 (inputs req, ptr; output one-hot grant); the adder SHALL be an instance of kogg_stone_64 with clk/reset connected.
REQ-030 The implementation SHALL have no combinational path from rsp_ready to rsp_valid, rsp_sum or rsp_id.

Verification
REQ-031 The bench SHALL cover: requester 0 with a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, rsp_ready=1 -> rsp_sum=0x0, rsp_id=0, rsp_valid 2 edges after accept.
REQ-032 The bench SHALL cover: all four req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0,1... with one response per cycle.
REQ-033 The bench SHALL cover: rsp_ready=0 for 5 cycles with 3 pending -> exactly 2 accepted, then req_ready=0, rsp stable; on release, all 3 responses arrive in order.
REQ-034 The bench SHALL cover: after a grant to 3, requesters 1 and 3 valid -> ptr=0, requester 1 granted next, then 3.
REQ-035 The bench SHALL cover: 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 -> rsp_sum=0x0 (carry dropped); 0x0123_4567_89AB_CDEF + 0x1111_1111_1111_1111 -> 0x1234_5678_9ABC_DF00.
REQ-036 The bench SHALL cover: reset asserted with both stages full -> rsp_valid=0 and ptr=0 after the edge, and no stale response afterwards.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared sizes and types for the shared-adder arbiter.
package adder_share_pkg;

  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int ID_W = 2;

  typedef logic [ID_W-1:0] req_id_t;

  function automatic req_id_t onehot_to_id(input logic [NREQ-1:0] oh);
    req_id_t id;
    case (oh)
      4'b0001: id = 2'd0;
      4'b0010: id = 2'd1;
      4'b0100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/kogg_stone_64.sv
// 64-bit Kogge-Stone adder; the sum is captured into an enabled result register.
module kogg_stone_64
  import adder_share_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_q
);

  localparam int LVL = 6;

  logic [W-1:0] hp_s;
  logic [W-1:0] sum_s;
  logic [W-2:0] g_s [0:LVL];
  logic [W-2:0] p_s [0:LVL-1];

  // parallel-prefix carry tree; the top carry is never needed since carry-out is dropped
  always_comb begin
    hp_s   = a ^ b;
    g_s[0] = a[W-2:0] & b[W-2:0];
    p_s[0] = hp_s[W-2:0];
    for (int l = 0; l < LVL - 1; l++) begin
      for (int i = 0; i < W - 1; i++) begin
        if (i >= (1 << l)) begin
          p_s[l+1][i] = p_s[l][i] & p_s[l][i-(1<<l)];
        end else begin
          p_s[l+1][i] = p_s[l][i];
        end
      end
    end
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < W - 1; i++) begin
        if (i >= (1 << l)) begin
          g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][i-(1<<l)]);
        end else begin
          g_s[l+1][i] = g_s[l][i];
        end
      end
    end
    sum_s = hp_s ^ {g_s[LVL], 1'b0};
  end

  // result register
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 64'd0;
    end else if (en) begin
      sum_q <= sum_s;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: the search starts at ptr and wraps.
module rr_arbiter_4
  import adder_share_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_id_t         ptr,
  output logic [NREQ-1:0] grant
);

  logic    found_s;
  req_id_t idx_s;

  // first requester at or after ptr wins
  always_comb begin
    grant   = 4'b0000;
    found_s = 1'b0;
    idx_s   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = ptr + 2'(k);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Four requesters share one 64-bit adder through a two-stage valid/ready pipeline.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic [1:0]        rsp_id
);

  logic            s1_valid_r;
  logic [W-1:0]    s1_a_r;
  logic [W-1:0]    s1_b_r;
  req_id_t         s1_id_r;
  req_id_t         ptr_r;
  logic            rsp_valid_r;
  req_id_t         rsp_id_r;
  logic [W-1:0]    sum_r;

  logic            s1_en_s;
  logic            s2_en_s;
  logic            accept_s;
  logic [NREQ-1:0] grant_s;
  logic [NREQ-1:0] req_ready_s;
  req_id_t         grant_id_s;
  logic [W-1:0]    a_sel_s;
  logic [W-1:0]    b_sel_s;

  rr_arbiter_4 u_arb (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  kogg_stone_64 u_add (
    .clk   (clk),
    .reset (reset),
    .en    (s2_en_s & s1_valid_r),
    .a     (s1_a_r),
    .b     (s1_b_r),
    .sum_q (sum_r)
  );

  // stage enables and the gated grant; rsp_ready only reaches the enables, never the outputs
  always_comb begin
    s2_en_s = !rsp_valid_r || rsp_ready;
    s1_en_s = !s1_valid_r || s2_en_s;
    if (reset) begin
      req_ready_s = 4'b0000;
    end else if (s1_en_s) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = 4'b0000;
    end
    accept_s   = |req_ready_s;
    grant_id_s = onehot_to_id(grant_s);
  end

  // operand mux for the granted requester
  always_comb begin
    case (grant_id_s)
      2'd0:    begin a_sel_s = req_a[0   +: W]; b_sel_s = req_b[0   +: W]; end
      2'd1:    begin a_sel_s = req_a[W   +: W]; b_sel_s = req_b[W   +: W]; end
      2'd2:    begin a_sel_s = req_a[2*W +: W]; b_sel_s = req_b[2*W +: W]; end
      2'd3:    begin a_sel_s = req_a[3*W +: W]; b_sel_s = req_b[3*W +: W]; end
      default: begin a_sel_s = req_a[0   +: W]; b_sel_s = req_b[0   +: W]; end
    endcase
  end

  // stage 1 operands and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 64'd0;
      s1_b_r     <= 64'd0;
      s1_id_r    <= 2'd0;
      ptr_r      <= 2'd0;
    end else if (s1_en_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r  <= a_sel_s;
        s1_b_r  <= b_sel_s;
        s1_id_r <= grant_id_s;
        ptr_r   <= grant_id_s + 2'd1;
      end
    end
  end

  // stage 2 valid and id; the sum register lives in the adder and shares this enable
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 2'd0;
    end else if (s2_en_s) begin
      rsp_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        rsp_id_r <= s1_id_r;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = sum_r;
  assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed-vector bench for adder_share_arbiter; each task checks its own scenario inline.
module tb_adder_share_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_sum;
  logic [1:0]   rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_share_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_sum !== 64'd0) begin errors++; $display("FAIL reset_sum got %h want 0", rsp_sum); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    checks++; if (dut.ptr_r !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dut.ptr_r); end
    reset = 1'b0; req_valid = 4'b0000;
  endtask

  task automatic test_wrap;
    set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_early got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_sum !== 64'd0) begin errors++; $display("FAIL wrap_sum got %h want 0", rsp_sum); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL wrap_id got %0d want 0", rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got %b want 0", rsp_valid); end
  endtask

  // ptr is 1 on entry: requester 2 then requester 1 (search from 3 wraps to 1)
  task automatic test_carry;
    set_op(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_ready2 got %b want 0100", req_ready); end
    tick();
    set_op(1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL carry_ready1 got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL carry_rsp2 got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id); end
    checks++; if (rsp_sum !== 64'd0) begin errors++; $display("FAIL carry_sum2 got %h want 0", rsp_sum); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL carry_rsp1 got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
    checks++; if (rsp_sum !== 64'h1234_5678_9ABC_DF00) begin errors++; $display("FAIL carry_sum1 got %h want 123456789abcdf00", rsp_sum); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [3:0]  exp_ready;
    logic [63:0] exp_sum;
    int          id;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 64'(i + 1) << 12, 64'(i + 1));
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1;
      exp_ready = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", k, req_ready, exp_ready); end
      if (k >= 2 && k < 10) begin
        id = (k - 2) % 4;
        exp_sum = (64'(id + 1) << 12) + 64'(id + 1);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(id)) begin errors++; $display("FAIL b2b_rsp[%0d] got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, id); end
        checks++; if (rsp_sum !== exp_sum) begin errors++; $display("FAIL b2b_sum[%0d] got %h want %h", k, rsp_sum, exp_sum); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got %b want 0", k, rsp_valid); end
      end
      tick();
      if (k == 7) req_valid = 4'b0000;
    end
  endtask

  task automatic test_stall;
    logic [3:0] exp_ready [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] pend;
    int         acc;
    int         eid;
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, 64'(10 * (i + 1)), 64'd7);
    pend = 4'b0111;
    acc  = 0;
    for (int k = 0; k < 9; k++) begin
      req_valid = pend;
      rsp_ready = (k >= 5);
      #1;
      checks++; if (req_ready !== exp_ready[k]) begin errors++; $display("FAIL stall_ready[%0d] got %b want %b", k, req_ready, exp_ready[k]); end
      if (k >= 2 && k <= 7) begin
        eid = (k <= 5) ? 0 : k - 5;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(eid)) begin errors++; $display("FAIL stall_rsp[%0d] got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, eid); end
        checks++; if (rsp_sum !== 64'(10 * (eid + 1) + 7)) begin errors++; $display("FAIL stall_sum[%0d] got %0d want %0d", k, rsp_sum, 10 * (eid + 1) + 7); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_idle[%0d] got %b want 0", k, rsp_valid); end
      end
      if (k < 5) acc += $countones(req_ready);
      pend = pend & ~req_ready;
      tick();
    end
    req_valid = 4'b0000;
    checks++; if (acc !== 2) begin errors++; $display("FAIL stall_accepts got %0d want 2", acc); end
  endtask

  task automatic test_ptr_skip;
    do_reset();
    rsp_ready = 1'b1;
    set_op(3, 64'd3, 64'd3);
    set_op(1, 64'd1, 64'd1);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_first got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b1010;
    #1;
    checks++; if (dut.ptr_r !== 2'd0) begin errors++; $display("FAIL skip_ptr_wrap got %0d want 0", dut.ptr_r); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL skip_grant1 got %b want 0010", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_grant3 got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (dut.ptr_r !== 2'd0) begin errors++; $display("FAIL skip_ptr_end got %0d want 0", dut.ptr_r); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midflight;
    rsp_ready = 1'b0;
    set_op(0, 64'd5, 64'd6);
    set_op(1, 64'd7, 64'd8);
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b1 || dut.s1_valid_r !== 1'b1) begin errors++; $display("FAIL mid_full got rsp=%b s1=%b want 1 1", rsp_valid, dut.s1_valid_r); end
    reset = 1'b1; req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b want 0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || dut.ptr_r !== 2'd0) begin errors++; $display("FAIL mid_cleared got v=%b ptr=%0d want 0 0", rsp_valid, dut.ptr_r); end
    checks++; if (rsp_sum !== 64'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_data got sum=%h id=%0d want 0 0", rsp_sum, rsp_id); end
    reset = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d] got %b want 0", k, rsp_valid); end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b0;
    req_a = 256'd0; req_b = 256'd0;
    test_reset();
    test_wrap();
    test_carry();
    test_back_to_back();
    test_stall();
    test_ptr_skip();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
